// File: rtl/rom_bus_arbiter_pkg.sv
// Shared definitions for the micro-procedure ROM/register store: address map,
// arbiter FSM states and the access legality check.
package rom_pkg;

  localparam logic [31:0] GPR_START = 32'hffffc000;
  localparam logic [31:0] GPR_END   = 32'hffffc07c;
  localparam logic [31:0] TMP_START = 32'hffffc080;
  localparam logic [31:0] TMP_END   = 32'hffffc0fc;
  localparam logic [31:0] CON_START = 32'hffffc100;
  localparam logic [31:0] CON_END   = 32'hffffc1fc;
  localparam logic [31:0] RZ_START  = 32'hffffc200;
  localparam logic [31:0] RZ_END    = 32'hffffc200;
  localparam logic [31:0] PRC_START = 32'hffffe000;
  localparam logic [31:0] PRC_END   = 32'hffffffff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  // Offset form keeps the top region (ending at all-ones) free of a constant compare.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr - lo) <= (hi - lo);
  endfunction

  function automatic logic addr_legal(input logic [31:0] addr, input logic we);
    logic in_gpr, in_tmp, in_con, in_rz, in_prc;
    in_gpr = in_range(addr, GPR_START, GPR_END);
    in_tmp = in_range(addr, TMP_START, TMP_END);
    in_con = in_range(addr, CON_START, CON_END);
    in_rz  = in_range(addr, RZ_START, RZ_END);
    in_prc = in_range(addr, PRC_START, PRC_END);
    return (addr[1:0] == 2'b00)
        && (in_gpr || in_tmp || in_con || in_rz || in_prc)
        && !(we && in_con)
        && !(we && (addr == GPR_START));
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_if.sv
// Requester handshake and ROM address/strobe bundle for rom_bus_arbiter.
interface rom_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_err;
  logic [31:0]           resp_rdata;
  logic                  mem_we;
  logic [31:0]           mem_addr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr
  );
endinterface

// File: rtl/rom_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid index strictly after
// last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Serialises requester accesses onto the shared ROM/register-store port with
// round-robin priority; every transaction takes IDLE -> ISSUE -> RESP.
module rom_bus_arbiter
  import rom_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  rom_bus_arbiter_if.slave   bus,
  inout  wire  [31:0]        mem_data
);

  localparam int unsigned IDW = (NUM_REQ > 2) ? 2 : 1;

  state_e               state_q, state_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 we_q, we_d;
  logic                 legal_q, legal_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_idx;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_we;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .valid      (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_addr  = bus.req_addr[{grant_idx, 5'b0} +: 32];
  assign sel_wdata = bus.req_wdata[{grant_idx, 5'b0} +: 32];
  assign sel_we    = bus.req_we[grant_idx];

  assign bus.req_ready  = (state_q == ST_IDLE) ? grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;

  // The write strobe flop doubles as the bus driver enable, so the ROM
  // (which drives only while mem_we is low) can never overlap with us.
  assign mem_data = mem_we_q ? wdata_q : 'z;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    we_d         = we_q;
    legal_d      = legal_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          id_d         = grant_idx;
          we_d         = sel_we;
          wdata_d      = sel_wdata;
          legal_d      = addr_legal(sel_addr, sel_we);
          mem_addr_d   = sel_addr;
          mem_we_d     = sel_we & addr_legal(sel_addr, sel_we);
          last_grant_d = grant_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_we_d           = 1'b0;
        resp_valid_d[id_q] = 1'b1;
        resp_err_d         = !legal_q;
        if (legal_q && !we_q) begin
          resp_rdata_d = mem_data;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      we_q         <= 1'b0;
      legal_q      <= 1'b0;
      wdata_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      we_q         <= we_d;
      legal_q      <= legal_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: doc/rom_bus_arbiter.md
# rom_bus_arbiter

Arbitrates between NUM_REQ requesters (core micro-sequencer, loader, debug port) for the single tri-state port of the micro-procedure ROM/register store. It serialises requests with round-robin priority and drives mem_we, mem_addr and mem_data. It also samples read data from the shared bus and returns per-requester responses. Illegal accesses are filtered before they reach the bus.

## Interface
- NUM_REQ, 2: number of requesters (2..4).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  request pending per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  32*NUM_REQ  byte address; requester i at [32i+31:32i].
- req_wdata  in  32*NUM_REQ  write data, same packing.
- req_ready  out  NUM_REQ  request accepted this cycle (valid & ready).
- resp_valid  out  NUM_REQ  one-cycle response pulse to the originating requester.
- resp_err  out  1  qualifies resp_valid; access was illegal and not performed.
- resp_rdata  out  32  read data, valid with resp_valid; 0 for writes and errors.
- mem_we  out  1  bus write strobe, registered.
- mem_addr  out  32  bus address, registered.
- mem_data  inout  32  shared data bus; driven only while mem_we = 1, else high-Z.

## Operation
- FSM states: IDLE, ISSUE, RESP; each transaction takes exactly 3 cycles.
- IDLE: arbitration is combinational across valid requesters, round-robin starting after last_grant. Exactly one req_ready bit is set, for the winner; none are set if no request is valid. On acceptance the FSM latches id, we, addr and wdata. On the same edge it sets mem_addr = addr and mem_we = we & legal, updates last_grant = id, and moves to ISSUE.
- ISSUE: the bus holds the latched address.
  - Legal write: mem_data is driven with wdata, and the ROM commits at the edge ending ISSUE.
  - Read: mem_data is released; the edge ending ISSUE samples mem_data into the rdata register.
  - Next state: RESP, with mem_we cleared on that edge.
- RESP: resp_valid[id] = 1 and resp_err reflects the legality check. resp_rdata = sampled value for legal reads, else 0. Next state: IDLE.
- Legality check (done at acceptance, from the latched address):
  - Illegal: addr[1:0] != 0.
  - Illegal: address outside all mapped regions GPR 0xffffc000–0xffffc07c, TMP 0xffffc080–0xffffc0fc, CON 0xffffc100–0xffffc1fc, RZ 0xffffc200, PRC 0xffffe000–0xffffffff.
  - Illegal: write to CON.
  - Illegal: write to GPR 0 (0xffffc000).
- Illegal access handling: the FSM still runs IDLE→ISSUE→RESP for uniform latency. mem_we stays 0, the bus is never driven, and the sampled data is discarded.
- mem_data driver enable is the same flop as mem_we. The arbiter and ROM therefore never drive the bus in the same cycle; the ROM drives only when rst=1 and mem_we=0.
- Requests not granted must be held stable by the requester until req_ready is seen.

## Timing
- Reset values (rst=0 at a rising edge):
  - state = IDLE, last_grant = NUM_REQ-1 (requester 0 wins first).
  - mem_we = 0, mem_addr = 0, mem_data = high-Z.
  - req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0.
- Reset mid-transaction: the transaction is dropped and no response is issued. A write in ISSUE is aborted because mem_we clears on the reset edge.
- Accept at edge 0 → bus valid during cycle 1 → resp_valid during cycle 2 → next accept earliest at edge 3.
- Maximum throughput is 1 transaction per 3 cycles.
- req_ready is 0 in ISSUE and RESP; requests arriving there wait until IDLE.
- Simultaneous requests: winner = first valid index strictly after last_grant, wrapping modulo NUM_REQ. No requester waits more than NUM_REQ-1 transactions.
- resp_valid has no backpressure; the requester must accept it.

## Structure
- rom_pkg: region start/end localparams (GPR, TMP, CON, RZ, PRC), the FSM state encoding, and a legality function addr_legal(addr, we).
- One sub-module, rr_arbiter: parameterised NUM_REQ. Inputs: valid vector and last_grant. Outputs: one-hot grant and encoded index. Combinational only; the last_grant register lives in the parent.
- Also used by the future micro-sequencer for its own region checks.

## Test plan
- Single read: after reset, req0 reads 0xffffc104 → mem_addr = 0xffffc104 with mem_we = 0 in cycle 1. resp_valid[0] in cycle 2 with rdata 0x00000002 and err 0.
- Write then read: req1 writes 0xdeadbeef to 0xffffc084, then reads it → one cycle of mem_we = 1 with bus = 0xdeadbeef. The read returns 0xdeadbeef; the bench bus monitor detects no cycle with double drive (X).
- Fairness: req0 and req1 held valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1, each spaced exactly 3 cycles apart.
- Illegal accesses: each of the following produces resp_err = 1 and rdata 0, mem_we never asserts, and the next read of 0xffffc000 returns 0.
  - write to 0xffffc108 (CON)
  - write to 0xffffc000 (GPR 0)
  - read of 0xffffc002 (unaligned)
  - read of 0x00001000 (unmapped)
- Reset mid-write: rst = 0 asserted during ISSUE of a write to 0xffffe010 → mem_we = 0 and bus high-Z on the next cycle, no resp_valid, and the target word is unchanged.
- NUM_REQ = 4, all valid with last_grant = 2 → grant order 3,0,1,2.
